// File: rtl/mips_control_unit_pkg.sv
// Shared encodings for the MIPS-subset multi-cycle controller:
// FSM states, ALU/shifter opcodes, exception codes, mux selects and
// the opcode/funct values the controller recognises.
package mips_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_EXCEPTION = 3'd5
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_INVALID = 2'b01;
  localparam logic [1:0] EXC_OVF     = 2'b10;
  localparam logic [1:0] EXC_DIV0    = 2'b11;

  localparam logic [1:0] ALU1_A    = 2'b00;
  localparam logic [1:0] ALU1_PC   = 2'b01;
  localparam logic [1:0] ALU1_B    = 2'b10;
  localparam logic [1:0] ALU2_B    = 2'b00;
  localparam logic [1:0] ALU2_FOUR = 2'b01;
  localparam logic [1:0] ALU2_IMM  = 2'b10;
  localparam logic [1:0] ALU2_A    = 2'b11;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_RS   = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;
  localparam logic [1:0] PC_EXC  = 2'b11;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_SHIFT = 2'b01;
  localparam logic [1:0] WD_HI    = 2'b10;
  localparam logic [1:0] WD_LO    = 2'b11;

  localparam logic [1:0] WR_RT = 2'b00;
  localparam logic [1:0] WR_RD = 2'b01;
  localparam logic [1:0] WR_RS = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_XCHG = 6'h2D;

  // True when the opcode/funct pair is something this controller can run.
  function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_MFHI, FN_MFLO, FN_MULT, FN_DIV,
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_XCHG: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end else begin
      case (op)
        OP_J, OP_ADDI, OP_SLTI, OP_ANDI: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mips_control_unit.sv
// Multi-cycle main controller for the MIPS-subset CPU.
// state | meaning
// 0 RESET     | idle after reset, all outputs low
// 1 FETCH     | load IR, PC <= PC+4
// 2 DECODE    | J/JR resolve here; unsupported instructions trap
// 3 EXECUTE   | ALU/shift/HI-LO work; MULT/DIV wait for done
// 4 WRITEBACK | second half of XCHG (rs <= B)
// 5 EXCEPTION | PC <= exception vector, latched cause on exception_control
module mips_control_unit
  import mips_control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_in,
  input  logic [31:0] instruction,
  input  logic        zero_flag,
  input  logic        overflow_flag,
  input  logic        div_zero,
  input  logic        mult_done,
  input  logic        div_done,
  output logic [1:0]  mux_a,
  output logic [1:0]  mux_b,
  output logic [1:0]  mux_alu_1,
  output logic [1:0]  mux_alu_2,
  output logic        mux_shift_amt,
  output logic        mux_shift_src,
  output logic [1:0]  mux_pc,
  output logic        mux_address,
  output logic [1:0]  mux_wd_memory,
  output logic [1:0]  mux_wd_registers,
  output logic [1:0]  mux_wr_registers,
  output logic        mux_extend,
  output logic        mux_high,
  output logic        mux_low,
  output logic [3:0]  alu_control,
  output logic [1:0]  shift_control,
  output logic [1:0]  load_size_control,
  output logic [1:0]  store_size_control,
  output logic        pc_write_enable,
  output logic        instruction_write,
  output logic        memory_write,
  output logic        register_write,
  output logic        hi_write,
  output logic        lo_write,
  output logic [1:0]  exception_control,
  output logic [2:0]  current_state,
  output logic [3:0]  counter
);

  state_e     state_q, state_d;
  logic [3:0] counter_q, counter_d;
  logic [1:0] exc_q, exc_d;
  logic [1:0] exc_new;
  logic [5:0] op, fn;

  // Only opcode/funct steer control; the rest of the word and zero_flag are datapath-only.
  logic unused_inputs;
  assign unused_inputs = ^{instruction[25:6], zero_flag};

  assign op            = instruction[31:26];
  assign fn            = instruction[5:0];
  assign current_state = state_q;
  assign counter       = counter_q;

  // State, dwell counter and latched exception cause.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= ST_RESET;
      counter_q <= 4'd0;
      exc_q     <= EXC_NONE;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      exc_q     <= exc_d;
    end
  end

  // Next state, exception cause to latch, and saturating dwell counter.
  always_comb begin
    state_d = ST_RESET;
    exc_new = EXC_NONE;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (!is_supported(op, fn)) begin
          state_d = ST_EXCEPTION;
          exc_new = EXC_INVALID;
        end else if (op == OP_J || (op == OP_RTYPE && fn == FN_JR)) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        if (op == OP_RTYPE) begin
          case (fn)
            FN_ADD, FN_SUB: if (overflow_flag) begin
              state_d = ST_EXCEPTION;
              exc_new = EXC_OVF;
            end
            FN_MULT: if (!mult_done) state_d = ST_EXECUTE;
            FN_DIV: begin
              if (div_zero) begin
                state_d = ST_EXCEPTION;
                exc_new = EXC_DIV0;
              end else if (!div_done) begin
                state_d = ST_EXECUTE;
              end
            end
            FN_XCHG: state_d = ST_WRITEBACK;
            default: state_d = ST_FETCH;
          endcase
        end else if (op == OP_ADDI && overflow_flag) begin
          state_d = ST_EXCEPTION;
          exc_new = EXC_OVF;
        end
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_EXCEPTION: state_d = ST_FETCH;
      default:      state_d = ST_RESET;
    endcase

    exc_d = (state_d == ST_EXCEPTION) ? exc_new : EXC_NONE;

    if (state_d != state_q)     counter_d = 4'd0;
    else if (counter_q == 4'hF) counter_d = 4'hF;
    else                        counter_d = counter_q + 4'd1;
  end

  // Datapath controls decoded from state, instruction and flags.
  always_comb begin
    mux_a              = 2'b00;
    mux_b              = 2'b00;
    mux_alu_1          = 2'b00;
    mux_alu_2          = 2'b00;
    mux_shift_amt      = 1'b0;
    mux_shift_src      = 1'b0;
    mux_pc             = 2'b00;
    mux_address        = 1'b0;
    mux_wd_memory      = 2'b00;
    mux_wd_registers   = 2'b00;
    mux_wr_registers   = 2'b00;
    mux_extend         = 1'b0;
    mux_high           = 1'b0;
    mux_low            = 1'b0;
    alu_control        = 4'b0000;
    shift_control      = 2'b00;
    load_size_control  = 2'b00;
    store_size_control = 2'b00;
    pc_write_enable    = 1'b0;
    instruction_write  = 1'b0;
    memory_write       = 1'b0;
    register_write     = 1'b0;
    hi_write           = 1'b0;
    lo_write           = 1'b0;
    exception_control  = EXC_NONE;
    case (state_q)
      ST_FETCH: begin
        instruction_write = 1'b1;
        alu_control       = ALU_ADD;
        mux_alu_1         = ALU1_PC;
        mux_alu_2         = ALU2_FOUR;
        pc_write_enable   = 1'b1;
        mux_pc            = PC_ALU;
      end
      ST_DECODE: begin
        if (op == OP_J) begin
          pc_write_enable = 1'b1;
          mux_pc          = PC_JUMP;
        end else if (op == OP_RTYPE && fn == FN_JR) begin
          pc_write_enable = 1'b1;
          mux_pc          = PC_RS;
        end
      end
      ST_EXECUTE: begin
        if (op == OP_RTYPE) begin
          mux_wr_registers = WR_RD;
          case (fn)
            FN_ADD, FN_SUB: begin
              alu_control    = (fn == FN_ADD) ? ALU_ADD : ALU_SUB;
              register_write = !overflow_flag;
            end
            FN_AND, FN_OR, FN_SLT: begin
              alu_control    = (fn == FN_AND) ? ALU_AND : (fn == FN_OR) ? ALU_OR : ALU_SLT;
              register_write = 1'b1;
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              shift_control    = (fn == FN_SLL) ? SH_SLL : (fn == FN_SRL) ? SH_SRL : SH_SRA;
              mux_wd_registers = WD_SHIFT;
              register_write   = 1'b1;
            end
            FN_MFHI, FN_MFLO: begin
              mux_wd_registers = (fn == FN_MFHI) ? WD_HI : WD_LO;
              register_write   = 1'b1;
            end
            FN_MULT: begin
              hi_write = mult_done;
              lo_write = mult_done;
            end
            FN_DIV: begin
              mux_high = 1'b1;
              mux_low  = 1'b1;
              hi_write = div_done && !div_zero;
              lo_write = div_done && !div_zero;
            end
            FN_XCHG: begin
              mux_alu_2        = ALU2_A;
              mux_wr_registers = WR_RT;
              register_write   = 1'b1;
            end
            default: mux_wr_registers = WR_RD;
          endcase
        end else begin
          mux_alu_2        = ALU2_IMM;
          mux_wr_registers = WR_RT;
          case (op)
            OP_ADDI: begin
              alu_control    = ALU_ADD;
              register_write = !overflow_flag;
            end
            OP_ANDI: begin
              alu_control    = ALU_AND;
              mux_extend     = 1'b1;
              register_write = 1'b1;
            end
            OP_SLTI: begin
              alu_control    = ALU_SLT;
              register_write = 1'b1;
            end
            default: register_write = 1'b0;
          endcase
        end
      end
      ST_WRITEBACK: begin
        mux_alu_1        = ALU1_B;
        mux_wr_registers = WR_RS;
        register_write   = 1'b1;
      end
      ST_EXCEPTION: begin
        exception_control = exc_q;
        pc_write_enable   = 1'b1;
        mux_pc            = PC_EXC;
      end
      default: mux_a = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed bench for the multi-cycle MIPS control unit.
module tb_mips_control_unit;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [31:0] instruction;
  logic        zero_flag, overflow_flag, div_zero, mult_done, div_done;
  logic [1:0]  mux_a, mux_b, mux_alu_1, mux_alu_2, mux_pc, mux_wd_memory;
  logic [1:0]  mux_wd_registers, mux_wr_registers, shift_control;
  logic [1:0]  load_size_control, store_size_control, exception_control;
  logic        mux_shift_amt, mux_shift_src, mux_address, mux_extend, mux_high, mux_low;
  logic [3:0]  alu_control, counter;
  logic        pc_write_enable, instruction_write, memory_write, register_write;
  logic        hi_write, lo_write;
  logic [2:0]  current_state;
  logic [39:0] all_outs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_control_unit dut (
    .clk(clk), .reset_in(reset_in), .instruction(instruction),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag), .div_zero(div_zero),
    .mult_done(mult_done), .div_done(div_done),
    .mux_a(mux_a), .mux_b(mux_b), .mux_alu_1(mux_alu_1), .mux_alu_2(mux_alu_2),
    .mux_shift_amt(mux_shift_amt), .mux_shift_src(mux_shift_src), .mux_pc(mux_pc),
    .mux_address(mux_address), .mux_wd_memory(mux_wd_memory),
    .mux_wd_registers(mux_wd_registers), .mux_wr_registers(mux_wr_registers),
    .mux_extend(mux_extend), .mux_high(mux_high), .mux_low(mux_low),
    .alu_control(alu_control), .shift_control(shift_control),
    .load_size_control(load_size_control), .store_size_control(store_size_control),
    .pc_write_enable(pc_write_enable), .instruction_write(instruction_write),
    .memory_write(memory_write), .register_write(register_write),
    .hi_write(hi_write), .lo_write(lo_write), .exception_control(exception_control),
    .current_state(current_state), .counter(counter)
  );

  assign all_outs = {mux_a, mux_b, mux_alu_1, mux_alu_2, mux_shift_amt, mux_shift_src,
                     mux_pc, mux_address, mux_wd_memory, mux_wd_registers, mux_wr_registers,
                     mux_extend, mux_high, mux_low, alu_control, shift_control,
                     load_size_control, store_size_control, pc_write_enable,
                     instruction_write, memory_write, register_write, hi_write, lo_write,
                     exception_control};

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From FETCH, load an instruction and advance through DECODE into EXECUTE.
  task automatic goto_exec(input logic [31:0] instr);
    instruction = instr;
    step();
    step();
    chk("exec_state", int'(current_state), 3);
  endtask

  initial begin
    reset_in = 1'b0;
    instruction = 32'h0043_0820;
    zero_flag = 1'b0; overflow_flag = 1'b0; div_zero = 1'b0;
    mult_done = 1'b0; div_done = 1'b0;
    step();
    step();
    chk("rst_state", int'(current_state), 0);
    chk("rst_outs_zero", int'(all_outs != 40'd0), 0);
    chk("rst_counter", int'(counter), 0);
    reset_in = 1'b1;

    // FETCH
    step();
    chk("fetch_state", int'(current_state), 1);
    chk("fetch_iw", int'(instruction_write), 1);
    chk("fetch_pcw", int'(pc_write_enable), 1);
    chk("fetch_alu", int'(alu_control), 2);
    chk("fetch_alu1", int'(mux_alu_1), 1);
    chk("fetch_alu2", int'(mux_alu_2), 1);
    chk("fetch_mux_pc", int'(mux_pc), 0);
    step();
    chk("decode_state", int'(current_state), 2);
    chk("decode_pcw", int'(pc_write_enable), 0);
    step();
    chk("add_state", int'(current_state), 3);
    chk("add_alu", int'(alu_control), 2);
    chk("add_rw", int'(register_write), 1);
    chk("add_mux_ab", int'({mux_a, mux_b, mux_alu_1, mux_alu_2}), 0);
    chk("add_wd", int'(mux_wd_registers), 0);
    chk("add_wr", int'(mux_wr_registers), 1);
    chk("add_counter", int'(counter), 0);
    step();
    chk("add_back_fetch", int'(current_state), 1);

    goto_exec(32'h0043_0822);
    chk("sub_alu", int'(alu_control), 6);
    chk("sub_rw", int'(register_write), 1);
    step();
    goto_exec(32'h0043_082A);
    chk("slt_alu", int'(alu_control), 7);
    step();
    goto_exec(32'h0002_1103);
    chk("sra_shift", int'(shift_control), 2);
    chk("sra_wd", int'(mux_wd_registers), 1);
    chk("sra_alu", int'(alu_control), 0);
    chk("sra_rw", int'(register_write), 1);
    step();

    // JR: resolves in DECODE
    instruction = 32'h03E0_0008;
    step();
    chk("jr_state", int'(current_state), 2);
    chk("jr_pcw", int'(pc_write_enable), 1);
    chk("jr_mux_pc", int'(mux_pc), 1);
    step();
    chk("jr_fetch", int'(current_state), 1);

    // J
    instruction = 32'h0800_0010;
    step();
    chk("j_mux_pc", int'(mux_pc), 2);
    chk("j_pcw", int'(pc_write_enable), 1);
    step();
    chk("j_fetch", int'(current_state), 1);

    // MULT waits for mult_done
    goto_exec(32'h0022_0018);
    chk("mult_hw_wait", int'(hi_write), 0);
    chk("mult_lw_wait", int'(lo_write), 0);
    step();
    chk("mult_hold", int'(current_state), 3);
    chk("mult_cnt1", int'(counter), 1);
    step();
    chk("mult_cnt2", int'(counter), 2);
    mult_done = 1'b1;
    #1;
    chk("mult_hw", int'(hi_write), 1);
    chk("mult_lw", int'(lo_write), 1);
    chk("mult_mux_hi", int'(mux_high), 0);
    step();
    mult_done = 1'b0;
    chk("mult_fetch", int'(current_state), 1);

    // DIV waits for div_done
    goto_exec(32'h0022_001A);
    chk("div_hw_wait", int'(hi_write), 0);
    step();
    chk("div_hold", int'(current_state), 3);
    div_done = 1'b1;
    #1;
    chk("div_hw", int'(hi_write), 1);
    chk("div_lw", int'(lo_write), 1);
    chk("div_mux_hl", int'({mux_high, mux_low}), 3);
    step();
    div_done = 1'b0;
    chk("div_fetch", int'(current_state), 1);

    // DIV by zero, simultaneous done: zero wins
    goto_exec(32'h0022_001A);
    div_zero = 1'b1; div_done = 1'b1;
    #1;
    chk("div0_no_hw", int'(hi_write), 0);
    chk("div0_no_lw", int'(lo_write), 0);
    step();
    div_zero = 1'b0; div_done = 1'b0;
    chk("div0_state", int'(current_state), 5);
    chk("div0_exc", int'(exception_control), 3);
    chk("div0_mux_pc", int'(mux_pc), 3);
    chk("div0_pcw", int'(pc_write_enable), 1);
    step();
    chk("div0_fetch", int'(current_state), 1);
    chk("div0_exc_clr", int'(exception_control), 0);

    // ADD overflow
    goto_exec(32'h0043_0820);
    overflow_flag = 1'b1;
    #1;
    chk("ovf_rw", int'(register_write), 0);
    step();
    overflow_flag = 1'b0;
    chk("ovf_state", int'(current_state), 5);
    chk("ovf_exc", int'(exception_control), 2);
    step();
    chk("ovf_fetch", int'(current_state), 1);

    // Invalid opcode traps from DECODE
    instruction = 32'hFC00_0000;
    step();
    step();
    chk("inv_state", int'(current_state), 5);
    chk("inv_exc", int'(exception_control), 1);
    step();

    // I-type
    goto_exec(32'h2041_0005);
    chk("addi_alu", int'(alu_control), 2);
    chk("addi_alu2", int'(mux_alu_2), 2);
    chk("addi_ext", int'(mux_extend), 0);
    chk("addi_wr", int'(mux_wr_registers), 0);
    chk("addi_rw", int'(register_write), 1);
    step();
    goto_exec(32'h3041_0005);
    chk("andi_ext", int'(mux_extend), 1);
    chk("andi_alu", int'(alu_control), 0);
    step();

    // XCHG: EXECUTE then WRITEBACK
    goto_exec(32'h0022_082D);
    chk("xchg_rw", int'(register_write), 1);
    chk("xchg_wr", int'(mux_wr_registers), 0);
    chk("xchg_alu2", int'(mux_alu_2), 3);
    chk("xchg_cnt", int'(counter), 0);
    step();
    chk("xchg_wb_state", int'(current_state), 4);
    chk("xchg_wb_wr", int'(mux_wr_registers), 3);
    chk("xchg_wb_alu1", int'(mux_alu_1), 2);
    chk("xchg_wb_rw", int'(register_write), 1);
    chk("xchg_wb_cnt", int'(counter), 0);
    step();
    chk("xchg_fetch", int'(current_state), 1);
    chk("xchg_fetch_cnt", int'(counter), 0);

    // Counter saturation during a long MULT, then reset aborts it
    goto_exec(32'h0022_0018);
    repeat (17) step();
    chk("cnt_sat_state", int'(current_state), 3);
    chk("cnt_sat", int'(counter), 15);
    mult_done = 1'b1;
    reset_in = 1'b0;
    #1;
    chk("abort_state", int'(current_state), 0);
    chk("abort_hw", int'(hi_write), 0);
    chk("abort_cnt", int'(counter), 0);
    step();
    reset_in = 1'b1;
    mult_done = 1'b0;
    step();
    chk("post_rst_fetch", int'(current_state), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
